// File: rtl/calib_tx_sched.sv
// calib_tx_sched: queues completed calibration banks, streams each one as a
// framed byte sequence (header, payload read from the ping-pong RAM, XOR
// checksum) and then requests a W5500 send, holding the bank until done.
//
// Ports:
//   i_clk_50m, i_rst                 clock, async active-high reset
//   i_calib_make/pingpang/points     bank-complete pulse, write bank, count
//   o_rd_en/o_rd_bank/o_rd_addr      RAM read port, i_rd_data one cycle later
//   o_tx_valid/data/last, i_tx_ready byte stream toward the TX FIFO
//   o_send_req, i_send_done          W5500 send handshake
//   o_busy, o_drop_cnt               status
module calib_tx_sched #(
  parameter int unsigned MAX_POINTS = 128,
  parameter logic [7:0]  HDR0       = 8'hAA,
  parameter logic [7:0]  HDR1       = 8'h55
) (
  input  logic        i_clk_50m,
  input  logic        i_rst,
  input  logic        i_calib_make,
  input  logic        i_calib_pingpang,
  input  logic [15:0] i_calib_points,
  output logic        o_rd_en,
  output logic        o_rd_bank,
  output logic [9:0]  o_rd_addr,
  input  logic [7:0]  i_rd_data,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_last,
  input  logic        i_tx_ready,
  output logic        o_send_req,
  input  logic        i_send_done,
  output logic        o_busy,
  output logic [7:0]  o_drop_cnt
);

  localparam int unsigned PTS_W  = 16;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CNT_W  = 11;

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_PAYLOAD, S_CSUM, S_SEND, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         pend;
  logic [PTS_W-1:0]   pts [2];
  logic               newest;
  logic               cur;
  logic [1:0]         hdr_idx;
  logic [7:0]         csum;
  logic [7:0]         tx_hold;
  logic               rd_vld;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               tx_valid;
  logic               tx_last;
  logic [7:0]         drop_cnt;

  logic               accept;
  logic               mk_bank;
  logic               mk_valid;
  logic               mk_reject;
  logic [PTS_W-1:0]   pts_clamp;
  logic [CNT_W-1:0]   byte_cnt;
  logic               at_last;
  logic [7:0]         csum_nxt;
  logic               pick;

  assign accept    = tx_valid & i_tx_ready;
  assign mk_bank   = ~i_calib_pingpang;
  assign mk_valid  = i_calib_make && (i_calib_points != '0);
  // A bank still owned by the sender (including DONE) cannot be refilled.
  assign mk_reject = pend[mk_bank] || ((state != S_IDLE) && (cur == mk_bank));
  assign pts_clamp = (i_calib_points > PTS_W'(MAX_POINTS)) ? PTS_W'(MAX_POINTS)
                                                           : i_calib_points;
  // pts <= 128, so the low byte times 8 fits in 11 bits (1024 max).
  assign byte_cnt  = {pts[cur][7:0], 3'b000};
  assign at_last   = ({1'b0, rd_addr} == (byte_cnt - CNT_W'(1)));
  assign csum_nxt  = rd_vld ? (csum ^ i_rd_data) : csum;
  // Both pending: the older bank is the one not made most recently.
  assign pick      = (pend == 2'b11) ? ~newest : pend[1];

  // State register
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pend != 2'b00)               state_nxt = S_HEADER;
      S_HEADER:  if (accept && (hdr_idx == 2'd3)) state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (accept && at_last)           state_nxt = S_CSUM;
      S_CSUM:    if (accept)                      state_nxt = S_SEND;
      S_SEND:    if (i_send_done)                 state_nxt = S_DONE;
      S_DONE:                                     state_nxt = S_IDLE;
      default:                                    state_nxt = S_IDLE;
    endcase
  end

  // Output decode; a freshly returned RAM byte is forwarded directly in its
  // return cycle and afterwards presented from the hold register.
  always_comb begin
    o_busy     = (state != S_IDLE);
    o_send_req = (state == S_SEND);
    o_tx_data  = rd_vld ? i_rd_data : tx_hold;
  end

  assign o_rd_en    = rd_en;
  assign o_rd_bank  = cur;
  assign o_rd_addr  = rd_addr;
  assign o_tx_valid = tx_valid;
  assign o_tx_last  = tx_last;
  assign o_drop_cnt = drop_cnt;

  // Pending table, framing datapath and drop counter
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      pend     <= '0;
      pts[0]   <= '0;
      pts[1]   <= '0;
      newest   <= 1'b0;
      cur      <= 1'b0;
      hdr_idx  <= '0;
      csum     <= '0;
      tx_hold  <= '0;
      rd_vld   <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_vld) begin
        csum    <= csum ^ i_rd_data;
        tx_hold <= i_rd_data;
      end

      case (state)
        S_IDLE: begin
          if (pend != 2'b00) begin
            cur      <= pick;
            hdr_idx  <= '0;
            csum     <= '0;
            tx_valid <= 1'b1;
            tx_hold  <= HDR0;
          end
        end
        S_HEADER: begin
          if (accept) begin
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd0:    tx_hold <= HDR1;
              2'd1:    tx_hold <= pts[cur][15:8];
              2'd2:    tx_hold <= pts[cur][7:0];
              default: begin
                tx_valid <= 1'b0;
                rd_en    <= 1'b1;
                rd_addr  <= '0;
              end
            endcase
          end
        end
        S_PAYLOAD: begin
          if (rd_en) begin
            rd_en    <= 1'b0;
            tx_valid <= 1'b1;
          end else if (accept) begin
            if (at_last) begin
              tx_valid <= 1'b1;
              tx_last  <= 1'b1;
              tx_hold  <= csum_nxt;
            end else begin
              tx_valid <= 1'b0;
              rd_en    <= 1'b1;
              rd_addr  <= rd_addr + ADDR_W'(1);
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
          end
        end
        S_DONE:  pend[cur] <= 1'b0;
        default: ;
      endcase

      // An accepted make never targets cur while in DONE, so it cannot
      // collide with the pend clear above.
      if (mk_valid) begin
        if (mk_reject) begin
          if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end else begin
          pend[mk_bank] <= 1'b1;
          pts[mk_bank]  <= pts_clamp;
          newest        <= mk_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_calib_tx_sched.sv
// Testbench for calib_tx_sched: table of single-frame cases plus directed
// sequences for queueing/rejection, reset mid-frame and drop saturation.
module tb_calib_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_calib_make;
  logic        i_calib_pingpang;
  logic [15:0] i_calib_points;
  logic        o_rd_en;
  logic        o_rd_bank;
  logic [9:0]  o_rd_addr;
  logic [7:0]  rd_data;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_last;
  logic        i_tx_ready;
  logic        o_send_req;
  logic        i_send_done;
  logic        o_busy;
  logic [7:0]  o_drop_cnt;

  calib_tx_sched dut (
    .i_clk_50m        (clk),
    .i_rst            (rst),
    .i_calib_make     (i_calib_make),
    .i_calib_pingpang (i_calib_pingpang),
    .i_calib_points   (i_calib_points),
    .o_rd_en          (o_rd_en),
    .o_rd_bank        (o_rd_bank),
    .o_rd_addr        (o_rd_addr),
    .i_rd_data        (rd_data),
    .o_tx_valid       (o_tx_valid),
    .o_tx_data        (o_tx_data),
    .o_tx_last        (o_tx_last),
    .i_tx_ready       (i_tx_ready),
    .o_send_req       (o_send_req),
    .i_send_done      (i_send_done),
    .o_busy           (o_busy),
    .o_drop_cnt       (o_drop_cnt)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] ram_byte(input logic bank, input int unsigned addr);
    return 8'((addr * 32'd37) ^ (addr >> 5) ^ (bank ? 32'h96 : 32'h3C));
  endfunction

  // Synchronous-read RAM; garbage when not read so held data is exercised.
  always @(posedge clk)
    rd_data <= o_rd_en ? ram_byte(o_rd_bank, 32'(o_rd_addr)) : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready generator and byte monitor
  int          ready_mode = 0;   // 0 high, 1 random, 2 low
  int          cyc = 0;
  int          last_cnt = 0;
  int          last_cyc = 0;
  int          rd_addr_last = 0;
  bit          seen_req = 0;
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_data = 8'h00;
  logic        stall_last = 1'b0;
  logic [8:0]  rx_q [$];
  logic [8:0]  exp_q [$];

  always @(negedge clk) begin
    cyc++;
    case (ready_mode)
      0:       i_tx_ready = 1'b1;
      1:       i_tx_ready = 1'($urandom_range(0, 1));
      default: i_tx_ready = 1'b0;
    endcase
    #1;
    if (!rst) begin
      if (stall_prev)
        check("stall hold", {22'd0, o_tx_valid, o_tx_last, o_tx_data},
              {22'd0, 1'b1, stall_last, stall_data});
      stall_prev = o_tx_valid && !i_tx_ready;
      stall_data = o_tx_data;
      stall_last = o_tx_last;
      if (o_tx_valid && i_tx_ready) begin
        rx_q.push_back({o_tx_last, o_tx_data});
        if (o_tx_last) begin
          last_cnt++;
          last_cyc = cyc;
        end
      end
      if (o_send_req) seen_req = 1'b1;
      if (o_rd_en) rd_addr_last = int'(o_rd_addr);
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic append_frame(input logic bank, input int n);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'(n >> 8)});
    exp_q.push_back({1'b0, 8'(n)});
    for (int a = 0; a < n * 8; a++) begin
      b  = ram_byte(bank, 32'(a));
      cs = cs ^ b;
      exp_q.push_back({1'b0, b});
    end
    exp_q.push_back({1'b1, cs});
  endtask

  task automatic compare_stream(input string name);
    int bad;
    int lim;
    bad = -1;
    check({name, " length"}, 32'(rx_q.size()), 32'(exp_q.size()));
    lim = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++)
      if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s bytes: index %0d got %0h expected %0h",
               name, bad, rx_q[bad], exp_q[bad]);
    end
  endtask

  task automatic make(input logic ping, input logic [15:0] pts);
    @(negedge clk);
    i_calib_make     = 1'b1;
    i_calib_pingpang = ping;
    i_calib_points   = pts;
    @(negedge clk);
    i_calib_make     = 1'b0;
  endtask

  task automatic wait_last(input int target, input string name);
    int n;
    n = 0;
    while (last_cnt < target && n < 40000) begin
      @(negedge clk);
      n++;
    end
    #2;
    check(name, 32'(last_cnt >= target), 32'd1);
  endtask

  task automatic wait_rd(input string name);
    int n;
    n = 0;
    while (!o_rd_en && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 32'(o_rd_en), 32'd1);
  endtask

  // Done pulse, then busy must hold one cycle and drop the next.
  task automatic finish_send(input string name);
    @(negedge clk);
    i_send_done = 1'b1;
    @(negedge clk);
    i_send_done = 1'b0;
    #1;
    check({name, " done+1"}, {30'd0, o_busy, o_send_req}, {30'd0, 2'b10});
    @(negedge clk);
    #1;
    check({name, " done+2"}, 32'(o_busy), 32'd0);
  endtask

  function automatic logic [31:0] out_vec();
    return {o_rd_en, o_rd_bank, o_rd_addr, o_tx_valid, o_tx_data,
            o_tx_last, o_send_req, o_busy, o_drop_cnt};
  endfunction

  typedef struct {
    logic        ping;
    logic [15:0] points;
    logic        frame;
    logic        bank;
    int          n;
    int          rmode;
  } vec_t;

  vec_t vecs [6];
  int   c0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ping: 1'b1, points: 16'd2,   frame: 1'b1, bank: 1'b0, n: 2,   rmode: 0};
    vecs[1] = '{ping: 1'b0, points: 16'd5,   frame: 1'b1, bank: 1'b1, n: 5,   rmode: 1};
    vecs[2] = '{ping: 1'b1, points: 16'd128, frame: 1'b1, bank: 1'b0, n: 128, rmode: 1};
    vecs[3] = '{ping: 1'b0, points: 16'd300, frame: 1'b1, bank: 1'b1, n: 128, rmode: 0};
    vecs[4] = '{ping: 1'b1, points: 16'd0,   frame: 1'b0, bank: 1'b0, n: 0,   rmode: 0};
    vecs[5] = '{ping: 1'b0, points: 16'd1,   frame: 1'b1, bank: 1'b1, n: 1,   rmode: 0};

    rst              = 1'b1;
    i_calib_make     = 1'b0;
    i_calib_pingpang = 1'b0;
    i_calib_points   = 16'd0;
    i_send_done      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset outputs", out_vec(), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      ready_mode = vecs[v].rmode;
      rx_q.delete();
      exp_q.delete();
      last_cnt = 0;
      make(vecs[v].ping, vecs[v].points);
      #1;
      check($sformatf("vec%0d make+1 idle", v), {30'd0, o_tx_valid, o_busy}, 32'd0);
      @(negedge clk);
      #1;
      if (vecs[v].frame) begin
        check($sformatf("vec%0d make+2 hdr0", v), {22'd0, o_tx_valid, o_busy, o_tx_data},
              {22'd0, 2'b11, 8'hAA});
        c0 = cyc;
        wait_last(1, $sformatf("vec%0d frame end", v));
        check($sformatf("vec%0d send_req", v), 32'(o_send_req), 32'd1);
        if (vecs[v].rmode == 0)
          check($sformatf("vec%0d frame cycles", v), 32'(last_cyc - c0 + 1),
                32'(5 + 16 * vecs[v].n));
        append_frame(vecs[v].bank, vecs[v].n);
        compare_stream($sformatf("vec%0d stream", v));
        check($sformatf("vec%0d last rd_addr", v), 32'(rd_addr_last), 32'(vecs[v].n * 8 - 1));
        repeat (3) @(negedge clk);
        #1;
        check($sformatf("vec%0d send_req held", v), 32'(o_send_req), 32'd1);
        finish_send($sformatf("vec%0d", v));
      end else begin
        check($sformatf("vec%0d no frame", v), {30'd0, o_tx_valid, o_busy}, 32'd0);
        @(negedge clk);
        i_send_done = 1'b1;
        @(negedge clk);
        i_send_done = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check($sformatf("vec%0d idle after", v), {o_busy, 31'(rx_q.size())}, 32'd0);
      end
      check($sformatf("vec%0d drop_cnt", v), 32'(o_drop_cnt), 32'd0);
    end

    // Queue while sending, reject a refill of the pending bank.
    ready_mode = 0;
    rx_q.delete();
    exp_q.delete();
    last_cnt = 0;
    make(1'b1, 16'd3);
    wait_rd("queue reach payload");
    make(1'b0, 16'd5);
    make(1'b1, 16'd7);
    #1;
    check("queue drop_cnt", 32'(o_drop_cnt), 32'd1);
    wait_last(1, "queue first frame");
    @(negedge clk);
    i_send_done = 1'b1;
    @(negedge clk);
    i_send_done = 1'b0;
    wait_last(2, "queue second frame");
    finish_send("queue");
    append_frame(1'b0, 3);
    append_frame(1'b1, 5);
    compare_stream("queue stream");

    // Reset during payload with both banks pending.
    rx_q.delete();
    last_cnt = 0;
    make(1'b1, 16'd4);
    wait_rd("rst reach payload");
    make(1'b0, 16'd4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid-frame reset outputs", out_vec(), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    seen_req = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    check("after reset quiet", {o_busy, seen_req, 30'(rx_q.size())}, 32'd0);

    // Drop counter saturation while a bank-0 frame is stalled in HEADER.
    ready_mode = 2;
    rx_q.delete();
    exp_q.delete();
    last_cnt = 0;
    make(1'b1, 16'd1);
    @(negedge clk);
    #1;
    check("sat stalled hdr0", {22'd0, o_tx_valid, o_busy, o_tx_data}, {22'd0, 2'b11, 8'hAA});
    @(negedge clk);
    i_send_done = 1'b1;
    @(negedge clk);
    i_send_done = 1'b0;
    @(negedge clk);
    i_calib_make     = 1'b1;
    i_calib_pingpang = 1'b1;
    i_calib_points   = 16'd1;
    repeat (100) @(negedge clk);
    i_calib_make = 1'b0;
    #1;
    check("drop_cnt 100", 32'(o_drop_cnt), 32'd100);
    @(negedge clk);
    i_calib_make = 1'b1;
    repeat (200) @(negedge clk);
    i_calib_make = 1'b0;
    #1;
    check("drop_cnt saturated", 32'(o_drop_cnt), 32'd255);
    ready_mode = 0;
    wait_last(1, "sat frame end");
    repeat (5) @(negedge clk);
    #1;
    check("sat send_req held", 32'(o_send_req), 32'd1);
    finish_send("sat");
    append_frame(1'b0, 1);
    compare_stream("sat stream");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
